// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Groups the requester bus and the uart_tx control/status signals of the
//   uart_tx arbiter into one bundle.
//   slave  : arbiter side (consumes requests and uart_tx status, drives grants
//            and uart_tx controls)
//   master : client/uart_tx side (the reverse directions)
// Signals
//   i_Req[NUM_REQ]       per-requester byte valid, held until o_Grant_Ack
//   i_Req_Byte[8*N]      byte k at [8k+7:8k]
//   i_Tx_Active          from uart_tx o_Tx_Active
//   i_Tx_Done            from uart_tx o_Tx_Done
//   o_Grant_Ack[N]       one-cycle pulse, byte k captured
//   o_Req_Done[N]        one-cycle pulse, byte k fully serialized
//   o_Grant_Id           index of current/last grantee
//   o_Busy               high whenever the arbiter is not idle
//   o_Tx_DV, o_Tx_Byte   to uart_tx i_Tx_DV / i_Tx_Byte
//   o_Timeout_Err        sticky watchdog flag
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic [NUM_REQ-1:0]   o_Grant_Ack;
  logic [NUM_REQ-1:0]   o_Req_Done;
  logic [IDW-1:0]       o_Grant_Id;
  logic                 o_Busy;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 o_Timeout_Err;

  modport slave (
    input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Grant_Ack, o_Req_Done, o_Grant_Id, o_Busy,
           o_Tx_DV, o_Tx_Byte, o_Timeout_Err
  );

  modport master (
    output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Grant_Ack, o_Req_Done, o_Grant_Id, o_Busy,
           o_Tx_DV, o_Tx_Byte, o_Timeout_Err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between NUM_REQ byte producers. Round-robin, one byte
//   per grant: capture byte, pulse uart_tx i_Tx_DV, wait for o_Tx_Done, then
//   one gap cycle before the next arbitration.
// Ports
//   i_Clock   system clock, rising edge
//   i_Reset   synchronous, active-high
//   bus       uart_tx_arbiter_if.slave (requests, grants, uart_tx control)
// Optional feature
//   UART_ARB_TIMEOUT_EN : WAIT_DONE watchdog of TIMEOUT_CLKS cycles; on expiry
//   o_Timeout_Err is set (sticky until reset) and the arbiter moves on without
//   a done pulse. Undefined: no watchdog, o_Timeout_Err tied 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrating; captures winner byte when uart_tx is not active
// LAUNCH    | byte captured, Grant_Ack visible; schedules the Tx_DV pulse
// WAIT_DONE | uart_tx serializing; waits for Tx_Done (or watchdog)
// GAP       | one idle cycle so uart_tx settles back to idle
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int TIMEOUT_CLKS = 1044
) (
  input logic             i_Clock,
  input logic             i_Reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CLKS_PER_BIT < 1 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gid_q, gid_d;
  logic [7:0]         byte_q, byte_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               dv_q, dv_d;

  logic [IDW-1:0]     win_id;
  logic               win_found;
  logic [7:0]         win_byte;
  logic [IDW-1:0]     rr_cand;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;
`endif

  // Round-robin search starting one past the last completed grantee.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && bus.i_Req[rr_cand]) begin
        win_found = 1'b1;
        win_id    = rr_cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDW'(k) == win_id) win_byte = bus.i_Req_Byte[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    byte_d  = byte_q;
    ack_d   = '0;
    done_d  = '0;
    dv_d    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A uart_tx still busy from elsewhere blocks the launch entirely.
        if (win_found && !bus.i_Tx_Active) begin
          byte_d         = win_byte;
          gid_d          = win_id;
          ack_d[win_id]  = 1'b1;
          state_d        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Registered so Tx_DV lands one cycle after Grant_Ack.
        dv_d    = 1'b1;
        state_d = S_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        tmr_d   = TW'(TIMEOUT_CLKS - 1);
`endif
      end
      S_WAIT_DONE: begin
        if (bus.i_Tx_Done) begin
          done_d[gid_q] = 1'b1;
          ptr_d         = gid_q;
          state_d       = S_GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmr_q == '0) begin
          timeout_d = 1'b1;
          ptr_d     = gid_q;
          state_d   = S_GAP;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      gid_q   <= '0;
      byte_q  <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      dv_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tmr_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      byte_q  <= byte_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      dv_q    <= dv_d;
`ifdef UART_ARB_TIMEOUT_EN
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.o_Grant_Ack = ack_q;
  assign bus.o_Req_Done  = done_q;
  assign bus.o_Grant_Id  = gid_q;
  assign bus.o_Busy      = (state_q != S_IDLE);
  assign bus.o_Tx_DV     = dv_q;
  assign bus.o_Tx_Byte   = byte_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.o_Timeout_Err = timeout_q;
`else
  assign bus.o_Timeout_Err = 1'b0;
`endif

endmodule
